// File: rtl/avalon_arb_pkg.sv
// Shared types and helpers for the Avalon-MM round-robin arbiter.
//   arb_state_t  : arbiter FSM states
//   TIMEOUT_DATA : read data returned on a watchdog-forced completion
//   rr_pick      : one-hot round-robin pick over up to MAX_MASTERS requesters
package avalon_arb_pkg;

    typedef enum logic [1:0] {IDLE, BUSY, LOCKED} arb_state_t;

    localparam int          MAX_MASTERS  = 8;
    localparam logic [31:0] TIMEOUT_DATA = 32'hDEADBEEF;

    // Scans req starting at ptr and wrapping modulo n. The result is the
    // rotate / find-first / unrotate pick, written as a wrapped index walk.
    // Bits at or above n are never set.
    function automatic logic [MAX_MASTERS-1:0] rr_pick(
        input logic [MAX_MASTERS-1:0] req,
        input logic [2:0]             ptr,
        input int                     n
    );
        logic [MAX_MASTERS-1:0] gnt;
        logic                   found;
        logic [3:0]             idx;
        gnt   = '0;
        found = 1'b0;
        for (int k = 0; k < MAX_MASTERS; k++) begin
            idx = {1'b0, ptr} + 4'(k);
            if (idx >= 4'(n)) idx = idx - 4'(n);
            if (k < n && !found && req[idx[2:0]]) begin
                gnt[idx[2:0]] = 1'b1;
                found         = 1'b1;
            end
        end
        return gnt;
    endfunction

endpackage

// File: rtl/rr_priority_picker.sv
// Combinational round-robin picker.
//   req   : per-master request vector
//   ptr   : index holding highest priority this round
//   grant : one-hot pick, zero when nothing requests
module rr_priority_picker
    import avalon_arb_pkg::*;
#(
    parameter int N = 2
) (
    input  logic [N-1:0] req,
    input  logic [2:0]   ptr,
    output logic [N-1:0] grant
);

    logic [MAX_MASTERS-1:0] req_ext;
    logic [MAX_MASTERS-1:0] gnt_ext;
    logic                   unused_hi;

    always_comb begin
        req_ext        = '0;
        req_ext[N-1:0] = req;
        gnt_ext        = rr_pick(req_ext, ptr, N);
        grant          = gnt_ext[N-1:0];
    end

    // Bits above N are always zero.
    assign unused_hi = ^gnt_ext;

endmodule

// File: rtl/avalon_mm_arbiter.sv
// Round-robin arbiter sharing one Avalon-MM slave port between N_MASTERS
// masters, one transfer per grant, with LOCK for atomic sequences.
//   CLK, RST                   : clock, async active-high reset
//   M_* (packed, master i at slice i) : master-side request/response
//   S_*                        : slave-side port, muxed from the owner
//   GRANT                      : one-hot current owner, zero when idle
// Optional: define AVALON_ARB_TIMEOUT_EN to add a waitrequest watchdog and
// the TIMEOUT_ERR output.
module avalon_mm_arbiter
    import avalon_arb_pkg::*;
#(
    parameter int N_MASTERS      = 2,
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                        CLK,
    input  logic                        RST,
    input  logic [N_MASTERS*ADDR_W-1:0] M_ADDRESS,
    input  logic [N_MASTERS*DATA_W-1:0] M_WRITEDATA,
    input  logic [N_MASTERS-1:0]        M_READ,
    input  logic [N_MASTERS-1:0]        M_WRITE,
    input  logic [N_MASTERS-1:0]        M_LOCK,
    output logic [N_MASTERS-1:0]        M_WAITREQUEST,
    output logic [DATA_W-1:0]           M_READDATA,
    output logic [ADDR_W-1:0]           S_ADDRESS,
    output logic [DATA_W-1:0]           S_WRITEDATA,
    output logic                        S_READ,
    output logic                        S_WRITE,
    output logic                        S_BEGINTRANSFER,
    output logic                        S_LOCK,
    input  logic                        S_WAITREQUEST,
    input  logic [DATA_W-1:0]           S_READDATA,
    output logic [N_MASTERS-1:0]        GRANT
`ifdef AVALON_ARB_TIMEOUT_EN
    ,
    output logic                        TIMEOUT_ERR
`endif
);

    arb_state_t           state_q, state_d;
    logic [N_MASTERS-1:0] grant_q, grant_d;
    logic [2:0]           ptr_q, ptr_d;
    logic                 first_q, first_d;   // first BUSY cycle of a transfer

    logic [N_MASTERS-1:0] req, pick;
    logic [ADDR_W-1:0]    g_addr;
    logic [DATA_W-1:0]    g_wdata;
    logic                 g_rd, g_wr, g_lock, g_req;
    logic [2:0]           g_idx, ptr_next;
    logic                 busy, done_ok, done, timeout;

    assign req = M_READ | M_WRITE;

    rr_priority_picker #(.N(N_MASTERS)) u_pick (
        .req   (req),
        .ptr   (ptr_q),
        .grant (pick)
    );

    // Owner's signals; all zero when nobody holds the grant.
    always_comb begin
        g_addr  = '0;
        g_wdata = '0;
        g_rd    = 1'b0;
        g_wr    = 1'b0;
        g_lock  = 1'b0;
        g_idx   = '0;
        for (int i = 0; i < N_MASTERS; i++) begin
            if (grant_q[i]) begin
                g_addr  = M_ADDRESS[i*ADDR_W +: ADDR_W];
                g_wdata = M_WRITEDATA[i*DATA_W +: DATA_W];
                g_rd    = M_READ[i];
                g_wr    = M_WRITE[i];
                g_lock  = M_LOCK[i];
                g_idx   = 3'(i);
            end
        end
    end

    assign busy     = (state_q == BUSY);
    assign g_req    = g_rd | g_wr;
    assign done_ok  = busy & g_req & ~S_WAITREQUEST;
    assign done     = done_ok | timeout;
    assign ptr_next = (g_idx == 3'(N_MASTERS - 1)) ? 3'd0 : g_idx + 3'd1;

`ifdef AVALON_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] cnt_q, cnt_d, cnt_cur;

    // Stall count restarts on every BEGINTRANSFER cycle.
    always_comb begin
        cnt_cur = first_q ? '0 : cnt_q;
        timeout = busy & g_req & S_WAITREQUEST &
                  (cnt_cur == CNT_W'(TIMEOUT_CYCLES - 1));
        cnt_d   = (busy & S_WAITREQUEST) ? cnt_cur + 1'b1 : '0;
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end

    assign TIMEOUT_ERR = timeout;
`else
    localparam int unused_timeout_cycles = TIMEOUT_CYCLES;
    assign timeout = 1'b0;
`endif

    // Slave side: driven only while a transfer is in BUSY. Both commands
    // high is treated as a read.
    assign S_ADDRESS       = busy ? g_addr  : '0;
    assign S_WRITEDATA     = busy ? g_wdata : '0;
    assign S_READ          = busy & g_rd;
    assign S_WRITE         = busy & g_wr & ~g_rd;
    assign S_BEGINTRANSFER = busy & first_q;
    assign S_LOCK          = g_lock;
    assign GRANT           = grant_q;

    // Everyone stalls except the owner on its completion cycle.
    assign M_WAITREQUEST = ~(grant_q & {N_MASTERS{done}});
    assign M_READDATA    = timeout ? DATA_W'(TIMEOUT_DATA) :
                           busy    ? S_READDATA : '0;

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        ptr_d   = ptr_q;
        first_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (|req) begin
                    grant_d = pick;
                    state_d = BUSY;
                    first_d = 1'b1;
                end
            end
            BUSY: begin
                if (!g_req) begin
                    // Owner withdrew mid-transfer: drop it, no rr update.
                    state_d = IDLE;
                    grant_d = '0;
                end else if (timeout || (done_ok && !g_lock)) begin
                    state_d = IDLE;
                    grant_d = '0;
                    ptr_d   = ptr_next;
                end else if (done_ok) begin
                    state_d = LOCKED;
                end
            end
            LOCKED: begin
                if (|(req & grant_q)) begin
                    state_d = BUSY;
                    first_d = 1'b1;
                end else if (!g_lock) begin
                    state_d = IDLE;
                    grant_d = '0;
                    ptr_d   = ptr_next;
                end
            end
            default: begin
                state_d = IDLE;
                grant_d = '0;
            end
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= IDLE;
            grant_q <= '0;
            ptr_q   <= '0;
            first_q <= 1'b0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            ptr_q   <= ptr_d;
            first_q <= first_d;
        end
    end

endmodule

// File: tb/tb_avalon_mm_arbiter.sv
// Scoreboard bench for avalon_mm_arbiter (2 masters, 32-bit).
module tb_avalon_mm_arbiter;

    localparam int N  = 2;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int TO = 16;

    logic            CLK = 1'b0;
    logic            RST;
    logic [N*AW-1:0] M_ADDRESS;
    logic [N*DW-1:0] M_WRITEDATA;
    logic [N-1:0]    M_READ, M_WRITE, M_LOCK, M_WAITREQUEST, GRANT;
    logic [DW-1:0]   M_READDATA, S_WRITEDATA, S_READDATA;
    logic [AW-1:0]   S_ADDRESS;
    logic            S_READ, S_WRITE, S_BEGINTRANSFER, S_LOCK, S_WAITREQUEST;
`ifdef AVALON_ARB_TIMEOUT_EN
    logic            TIMEOUT_ERR;
`endif

    avalon_mm_arbiter #(.N_MASTERS(N), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYCLES(TO)) dut (
        .CLK(CLK), .RST(RST),
        .M_ADDRESS(M_ADDRESS), .M_WRITEDATA(M_WRITEDATA),
        .M_READ(M_READ), .M_WRITE(M_WRITE), .M_LOCK(M_LOCK),
        .M_WAITREQUEST(M_WAITREQUEST), .M_READDATA(M_READDATA),
        .S_ADDRESS(S_ADDRESS), .S_WRITEDATA(S_WRITEDATA),
        .S_READ(S_READ), .S_WRITE(S_WRITE), .S_BEGINTRANSFER(S_BEGINTRANSFER),
        .S_LOCK(S_LOCK), .S_WAITREQUEST(S_WAITREQUEST), .S_READDATA(S_READDATA),
        .GRANT(GRANT)
`ifdef AVALON_ARB_TIMEOUT_EN
        , .TIMEOUT_ERR(TIMEOUT_ERR)
`endif
    );

    always #5 CLK = ~CLK;

    // Slave model: stalls stall_cfg cycles per transfer (or forever when
    // stuck); read data is rd_base XOR the presented address.
    logic        stuck = 1'b0;
    int          stall_cfg = 0;
    int          scnt = 0;
    logic [31:0] rd_base = '0;
    always @(posedge CLK)
        if ((S_READ || S_WRITE) && S_WAITREQUEST) scnt <= scnt + 1;
        else                                      scnt <= 0;
    assign S_WAITREQUEST = stuck || ((S_READ || S_WRITE) && scnt < stall_cfg);
    assign S_READDATA    = rd_base ^ S_ADDRESS;

    typedef struct {
        int          m;
        logic        chk;
        logic [31:0] rd;
        logic        to;
    } exp_t;
    exp_t sb[$];
    exp_t mon_e;
    int   n_vec = 0;
    int   n_err = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push(input int m, input logic c, input logic [31:0] rd, input logic to);
        exp_t e;
        e.m = m; e.chk = c; e.rd = rd; e.to = to;
        sb.push_back(e);
    endtask

    // Monitor: every completion seen by a master pops one expectation.
    always @(negedge CLK) begin
        if (!RST) begin
            for (int i = 0; i < N; i++) begin
                if (!M_WAITREQUEST[i]) begin
                    if (sb.size() == 0) begin
                        n_vec++; n_err++;
                        $display("FAIL unexpected_completion: master %0d, none expected", i);
                    end else begin
                        mon_e = sb.pop_front();
                        chk("sb_master", 64'(i), 64'(mon_e.m));
                        chk("sb_grant", 64'(GRANT), 64'(1 << i));
                        if (mon_e.chk) chk("sb_rdata", 64'(M_READDATA), 64'(mon_e.rd));
`ifdef AVALON_ARB_TIMEOUT_EN
                        chk("sb_timeout_err", 64'(TIMEOUT_ERR), 64'(mon_e.to));
`endif
                    end
                end
            end
        end
    end

    task automatic set_m(input int m, input logic rd, input logic wr, input logic lk,
                         input logic [31:0] a, input logic [31:0] d);
        M_READ[m]  = rd;
        M_WRITE[m] = wr;
        M_LOCK[m]  = lk;
        M_ADDRESS[m*AW +: AW]   = a;
        M_WRITEDATA[m*DW +: DW] = d;
    endtask

    // One transfer from a single master, checking grant latency, slave
    // command, begin pulse count and completion cycle.
    task automatic run_single(input int m, input logic rd, input logic [31:0] a,
                              input logic [31:0] d, input int stall, input int exp_edges,
                              input logic [31:0] exp_rd, input logic exp_to);
        int edges, begins;
        logic got;
        @(negedge CLK);
        stall_cfg = stall;
        set_m(m, rd, !rd, 1'b0, a, d);
        push(m, rd, exp_rd, exp_to);
        edges = 0; begins = 0; got = 1'b0;
        while (!got && edges < 200) begin
            @(negedge CLK);
            edges++;
            if (S_BEGINTRANSFER) begins++;
            if (edges == 1) begin
                chk("grant_latency", 64'(GRANT), 64'(1 << m));
                chk("s_address", 64'(S_ADDRESS), 64'(a));
                chk("s_cmd", 64'({S_READ, S_WRITE}), rd ? 64'd2 : 64'd1);
                if (!rd) chk("s_writedata", 64'(S_WRITEDATA), 64'(d));
            end
            if (!M_WAITREQUEST[m]) got = 1'b1;
        end
        chk("done_cycle", 64'(edges), 64'(exp_edges));
        chk("begin_pulses", 64'(begins), 64'd1);
        @(posedge CLK); #1;
        set_m(m, 1'b0, 1'b0, 1'b0, a, d);
        @(negedge CLK);
        chk("idle_grant", 64'(GRANT), 64'd0);
    endtask

    // Both masters read (addr 0x100*(i+1)); master i drops after want[i]
    // completions. Expected order is pushed by the caller.
    task automatic run_multi(input int want0, input int want1);
        int want[N];
        int done[N];
        int edges;
        want[0] = want0; want[1] = want1;
        stall_cfg = 0;
        @(negedge CLK);
        for (int i = 0; i < N; i++) begin
            done[i] = 0;
            if (want[i] > 0) set_m(i, 1'b1, 1'b0, 1'b0, 32'h100 * (i + 1), '0);
        end
        edges = 0;
        while ((done[0] < want[0] || done[1] < want[1]) && edges < 500) begin
            @(negedge CLK);
            edges++;
            for (int i = 0; i < N; i++) if (!M_WAITREQUEST[i]) done[i]++;
            @(posedge CLK); #1;
            for (int i = 0; i < N; i++)
                if (done[i] >= want[i]) set_m(i, 1'b0, 1'b0, 1'b0, '0, '0);
        end
        chk("multi_finished", 64'(edges < 500), 64'd1);
    endtask

    initial begin
        int c, e;
        RST = 1'b1;
        M_ADDRESS = '0; M_WRITEDATA = '0;
        M_READ = '0; M_WRITE = '0; M_LOCK = '0;
        #12;
        chk("rst_grant", 64'(GRANT), 64'd0);
        chk("rst_mwait", 64'(M_WAITREQUEST), 64'd3);
        chk("rst_scmd", 64'({S_READ, S_WRITE, S_BEGINTRANSFER, S_LOCK}), 64'd0);
        chk("rst_rdata", 64'(M_READDATA), 64'd0);
        @(negedge CLK); RST = 1'b0;

        // Single master write, slave stalls 3 cycles.
        run_single(0, 1'b0, 32'h0C, 32'h55, 3, 4, 32'h0, 1'b0);

        // Contention from rr=0: 0,1,0,1.
        @(negedge CLK); RST = 1'b1; @(negedge CLK); RST = 1'b0;
        rd_base = 32'h12345678;
        push(0, 1'b1, 32'h12345778, 1'b0);
        push(1, 1'b1, 32'h12345478, 1'b0);
        push(0, 1'b1, 32'h12345778, 1'b0);
        push(1, 1'b1, 32'h12345478, 1'b0);
        run_multi(2, 2);

        // Lock: M1 does 3 locked reads while M0 waits.
        rd_base = 32'hA0A0A0A0;
        push(1, 1'b1, 32'hA0A0A0E0, 1'b0);
        push(1, 1'b1, 32'hA0A0A0E0, 1'b0);
        push(1, 1'b1, 32'hA0A0A0E0, 1'b0);
        push(0, 1'b1, 32'hA0A0A020, 1'b0);
        @(negedge CLK);
        set_m(1, 1'b1, 1'b0, 1'b1, 32'h40, '0);
        @(negedge CLK);
        chk("lock_grant", 64'(GRANT), 64'd2);
        chk("lock_slock", 64'(S_LOCK), 64'd1);
        set_m(0, 1'b1, 1'b0, 1'b0, 32'h80, '0);
        c = 0; e = 0;
        while (c < 3 && e < 100) begin
            if (!M_WAITREQUEST[1]) c++;
            chk("lock_m0_wait", 64'(M_WAITREQUEST[0]), 64'd1);
            if (c < 3) begin @(negedge CLK); e++; end
        end
        chk("lock_three_done", 64'(c), 64'd3);
        @(posedge CLK); #1;
        set_m(1, 1'b0, 1'b0, 1'b0, '0, '0);
        @(negedge CLK);
        chk("locked_hold", 64'(GRANT), 64'd2);
        chk("locked_m0_wait", 64'(M_WAITREQUEST[0]), 64'd1);
        @(negedge CLK);
        chk("unlock_idle", 64'(GRANT), 64'd0);
        @(negedge CLK);
        chk("m0_after_lock", 64'(GRANT), 64'd1);
        @(posedge CLK); #1;
        set_m(0, 1'b0, 1'b0, 1'b0, '0, '0);

        // Read data, no stall: completes in the cycle after the grant edge.
        rd_base = 32'hCAFEF00D;
        run_single(0, 1'b1, 32'h0, 32'h0, 0, 1, 32'hCAFEF00D, 1'b0);

        // Reset in the middle of a stalled write.
        @(negedge CLK);
        stall_cfg = 10;
        set_m(1, 1'b0, 1'b1, 1'b0, 32'h44, 32'h99);
        @(negedge CLK);
        chk("mid_swrite", 64'(S_WRITE), 64'd1);
        #2 RST = 1'b1;
        #1;
        chk("arst_cmd", 64'({S_READ, S_WRITE, S_BEGINTRANSFER, S_LOCK}), 64'd0);
        chk("arst_grant", 64'(GRANT), 64'd0);
        chk("arst_mwait", 64'(M_WAITREQUEST), 64'd3);
        chk("arst_saddr", 64'(S_ADDRESS), 64'd0);
        chk("arst_swdata", 64'(S_WRITEDATA), 64'd0);
        chk("arst_rdata", 64'(M_READDATA), 64'd0);
        set_m(1, 1'b0, 1'b0, 1'b0, '0, '0);
        @(negedge CLK); RST = 1'b0;
        rd_base = 32'h0F0F0F0F;
        push(0, 1'b1, 32'h0F0F0E0F, 1'b0);
        push(1, 1'b1, 32'h0F0F0D0F, 1'b0);
        run_multi(1, 1);

`ifdef AVALON_ARB_TIMEOUT_EN
        // Stuck slave: watchdog completes the read on the 16th stall cycle.
        stuck = 1'b1;
        run_single(0, 1'b1, 32'h10, 32'h0, 0, TO, 32'hDEADBEEF, 1'b1);
        stuck = 1'b0;
        // Pointer moved past M0, so M1 goes first.
        rd_base = 32'h0;
        push(1, 1'b1, 32'h200, 1'b0);
        push(0, 1'b1, 32'h100, 1'b0);
        run_multi(1, 1);
`endif

        repeat (3) @(negedge CLK);
        chk("sb_empty", 64'(sb.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
